// File: rtl/core_pkg.sv
// Shared core definitions: data widths, the canonical NOP, and the
// {PC, instruction} fetch entry used by the fetch queue and decode.
package core_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   // addi x0, x0, 0
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   localparam int unsigned FETCH_ENTRY_W = XLEN + ILEN;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle. The master side is the fetch unit
// (push side, flush, decode's ready); the slave side is the fetch queue.
interface fetch_queue_if;
   import core_pkg::*;

   logic            push_valid;
   logic [XLEN-1:0] push_pc;
   logic [ILEN-1:0] push_instr;
   logic            push_ready;
   logic            flush;
   logic            pop_valid;
   logic [XLEN-1:0] pop_pc;
   logic [ILEN-1:0] pop_instr;
   logic            pop_illegal;
   logic            pop_ready;

   modport master (
      output push_valid, push_pc, push_instr, flush, pop_ready,
      input  push_ready, pop_valid, pop_pc, pop_instr, pop_illegal
   );

   modport slave (
      input  push_valid, push_pc, push_instr, flush, pop_ready,
      output push_ready, pop_valid, pop_pc, pop_instr, pop_illegal
   );

endinterface

// File: rtl/fq_storage.sv
// DEPTH x {PC, instruction} register array for the fetch queue.
// One synchronous write port, one asynchronous read port, no reset.
module fq_storage
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  fetch_entry_t  wr_data,
   input  logic [AW-1:0] rd_addr,
   output fetch_entry_t  rd_data
);

   logic [FETCH_ENTRY_W-1:0] mem_q [DEPTH];

   // Write the pushed entry at the write pointer.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: decouples instruction fetch from decode with an in-order
// {PC, instruction} FIFO, a valid/ready handshake on both sides, and a
// flush that discards all entries.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, an incoming
// entry is presented to decode combinationally and consumed without being
// stored if decode is ready.
module fetch_queue
   import core_pkg::*;
#(
   parameter int unsigned     DEPTH = 4,
   parameter logic [ILEN-1:0] NOP   = NOP_INSTR
) (
   input  logic         clk,
   input  logic         rst,
   fetch_queue_if.slave bus
);

   localparam int unsigned AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            empty, full, bypass, wr_en, rd_en;
   fetch_entry_t    wr_entry, head;
   logic [ILEN-1:0] out_instr;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_COUNT);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = empty && bus.push_valid && !bus.flush;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed entry taken by decode in the same cycle is never stored.
   assign wr_en = bus.push_valid && !full && !bus.flush && !(bypass && bus.pop_ready);
   assign rd_en = !empty && bus.pop_ready && !bus.flush;

   assign wr_entry = '{pc: bus.push_pc, instr: bus.push_instr};

   fq_storage #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_storage (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr_q),
      .rd_data (head)
   );

   // Handshake and head outputs; the empty queue shows PC 0 and a NOP.
   always_comb begin
      bus.push_ready = !full;
      bus.pop_valid  = !empty || bypass;
      bus.pop_pc     = '0;
      out_instr      = NOP;
      if (!empty) begin
         bus.pop_pc = head.pc;
         out_instr  = head.instr;
      end else if (bypass) begin
         bus.pop_pc = bus.push_pc;
         out_instr  = bus.push_instr;
      end
      bus.pop_instr   = out_instr;
      bus.pop_illegal = bus.pop_valid && (out_instr[1:0] != 2'b11);
   end

   // Pointer and count next state; flush overrides any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
         if (wr_en && !rd_en) begin
            count_d = count_q + (AW + 1)'(1);
         end else if (!wr_en && rd_en) begin
            count_d = count_q - (AW + 1)'(1);
         end
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH = 4).
// Each vector is driven after a falling edge and the outputs are compared
// 1 time unit later, i.e. the state left by the previous rising edge.
module tb_fetch_queue;
   import core_pkg::*;

   typedef struct {
      logic        pv;
      logic [63:0] pc;
      logic [31:0] instr;
      logic        pr;
      logic        fl;
      logic        ev;
      logic        erdy;
      logic [63:0] epc;
      logic [31:0] einstr;
      logic        eill;
   } vec_t;

   localparam logic [31:0] NOP_W = 32'h00000013;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   vec_t vecs[$];

   fetch_queue_if bus ();

   fetch_queue #(
      .DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [63:0] pc);
      return NOP_W | {pc[11:0], 20'h0};
   endfunction

   function automatic void add(input logic pv, input logic [63:0] pc, input logic [31:0] instr,
                               input logic pr, input logic fl, input logic ev, input logic erdy,
                               input logic [63:0] epc, input logic [31:0] einstr,
                               input logic eill);
      vec_t v;
      v.pv = pv; v.pc = pc; v.instr = instr; v.pr = pr; v.fl = fl;
      v.ev = ev; v.erdy = erdy; v.epc = epc; v.einstr = einstr; v.eill = eill;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic ev, input logic erdy,
                            input logic [63:0] epc, input logic [31:0] einstr, input logic eill);
      check({name, ".valid"},   64'(bus.pop_valid),   64'(ev));
      check({name, ".ready"},   64'(bus.push_ready),  64'(erdy));
      check({name, ".pc"},      bus.pop_pc,           epc);
      check({name, ".instr"},   64'(bus.pop_instr),   64'(einstr));
      check({name, ".illegal"}, 64'(bus.pop_illegal), 64'(eill));
   endtask

   task automatic drive(input logic pv, input logic [63:0] pc, input logic [31:0] instr,
                        input logic pr, input logic fl);
      bus.push_valid = pv;
      bus.push_pc    = pc;
      bus.push_instr = instr;
      bus.pop_ready  = pr;
      bus.flush      = fl;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

      // Reset state, then 10 idle cycles after release.
      #2;
      check_out("in_reset", 1'b0, 1'b1, 64'h0, NOP_W, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         check_out($sformatf("idle%0d", i), 1'b0, 1'b1, 64'h0, NOP_W, 1'b0);
      end

`ifndef FETCH_QUEUE_BYPASS_EN
      // Fill to full, rejected push (also with a same-cycle pop), drain in order.
      add(1, 64'h0,  instr_of(64'h0),  0, 0, 0, 1, 64'h0, NOP_W, 0);
      add(1, 64'h4,  instr_of(64'h4),  0, 0, 1, 1, 64'h0, instr_of(64'h0), 0);
      add(1, 64'h8,  instr_of(64'h8),  0, 0, 1, 1, 64'h0, instr_of(64'h0), 0);
      add(1, 64'hC,  instr_of(64'hC),  0, 0, 1, 1, 64'h0, instr_of(64'h0), 0);
      add(1, 64'h10, instr_of(64'h10), 0, 0, 1, 0, 64'h0, instr_of(64'h0), 0);
      add(1, 64'h10, instr_of(64'h10), 1, 0, 1, 0, 64'h0, instr_of(64'h0), 0);
      add(0, 64'h0,  32'h0,            1, 0, 1, 1, 64'h4, instr_of(64'h4), 0);
      add(0, 64'h0,  32'h0,            1, 0, 1, 1, 64'h8, instr_of(64'h8), 0);
      add(0, 64'h0,  32'h0,            1, 0, 1, 1, 64'hC, instr_of(64'hC), 0);
      add(0, 64'h0,  32'h0,            0, 0, 0, 1, 64'h0, NOP_W, 0);

      // Streaming push/pop for 12 cycles; the head lags the input by one cycle.
      for (int k = 0; k < 12; k++) begin
         logic [63:0] pc_in, pc_exp;
         pc_in  = 64'h100 + 64'(4 * k);
         pc_exp = 64'h100 + 64'(4 * (k - 1));
         if (k == 0) add(1, pc_in, instr_of(pc_in), 1, 0, 0, 1, 64'h0, NOP_W, 0);
         else        add(1, pc_in, instr_of(pc_in), 1, 0, 1, 1, pc_exp, instr_of(pc_exp), 0);
      end
      add(0, 64'h0, 32'h0, 1, 0, 1, 1, 64'h12C, instr_of(64'h12C), 0);
      add(0, 64'h0, 32'h0, 0, 0, 0, 1, 64'h0, NOP_W, 0);

      // Flush with three entries queued and a same-cycle push of 0x200.
      add(1, 64'h300, instr_of(64'h300), 0, 0, 0, 1, 64'h0,   NOP_W, 0);
      add(1, 64'h304, instr_of(64'h304), 0, 0, 1, 1, 64'h300, instr_of(64'h300), 0);
      add(1, 64'h308, instr_of(64'h308), 0, 0, 1, 1, 64'h300, instr_of(64'h300), 0);
      add(1, 64'h200, instr_of(64'h200), 1, 1, 1, 1, 64'h300, instr_of(64'h300), 0);
      add(0, 64'h0,   32'h0,             0, 0, 0, 1, 64'h0,   NOP_W, 0);
      add(0, 64'h0,   32'h0,             1, 0, 0, 1, 64'h0,   NOP_W, 0);

      // Illegal flag for a compressed encoding, clear for a normal one.
      add(1, 64'h400, 32'h00004501, 0, 0, 0, 1, 64'h0,   NOP_W,        0);
      add(1, 64'h404, 32'h00a00513, 0, 0, 1, 1, 64'h400, 32'h00004501, 1);
      add(0, 64'h0,   32'h0,        1, 0, 1, 1, 64'h400, 32'h00004501, 1);
      add(0, 64'h0,   32'h0,        1, 0, 1, 1, 64'h404, 32'h00a00513, 0);
      add(0, 64'h0,   32'h0,        0, 0, 0, 1, 64'h0,   NOP_W,        0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].pv, vecs[i].pc, vecs[i].instr, vecs[i].pr, vecs[i].fl);
         #1;
         check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erdy, vecs[i].epc,
                   vecs[i].einstr, vecs[i].eill);
      end
`else
      // Bypass: empty queue, decode stalled -> visible now, stored for later.
      @(negedge clk);
      drive(1'b1, 64'h40, instr_of(64'h40), 1'b0, 1'b0);
      #1;
      check_out("byp_stall", 1'b1, 1'b1, 64'h40, instr_of(64'h40), 1'b0);
      @(negedge clk);
      drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      #1;
      check_out("byp_stored", 1'b1, 1'b1, 64'h40, instr_of(64'h40), 1'b0);
      // Empty queue, decode ready -> consumed directly, never stored.
      @(negedge clk);
      drive(1'b1, 64'h44, instr_of(64'h44), 1'b1, 1'b0);
      #1;
      check_out("byp_direct", 1'b1, 1'b1, 64'h44, instr_of(64'h44), 1'b0);
      @(negedge clk);
      drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
      #1;
      check_out("byp_after", 1'b0, 1'b1, 64'h0, NOP_W, 1'b0);
`endif

      // Mid-operation asynchronous reset with two entries queued.
      @(negedge clk);
      drive(1'b1, 64'h500, instr_of(64'h500), 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 64'h504, instr_of(64'h504), 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
      #1;
      check_out("pre_rst", 1'b1, 1'b1, 64'h500, instr_of(64'h500), 1'b0);
      #1;
      rst = 1'b1;
      #1;
      check_out("async_rst", 1'b0, 1'b1, 64'h0, NOP_W, 1'b0);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_out("post_rst", 1'b0, 1'b1, 64'h0, NOP_W, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between instruction memory (instr) and the decode stage of the RV64 core.
- Captures {PC, instruction} pairs produced each cycle by pc/instr and presents them in order to decode with a valid/ready handshake.
- Lets decode stall without dropping fetched instructions.
- Discards everything on a branch-taken flush.

Parameters:
- DEPTH, 4, number of {PC, instruction} entries; power of two, minimum 2.
- NOP, 32'h00000013, instruction word presented on o_Instr when the queue is empty (addi x0,x0,0).

Ports:
- i_Clock  in  1  core clock; all state updates on the rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Valid  in  1  upstream fetch presents a valid {i_PC, i_Instr} this cycle.
- i_PC  in  64  PC of the fetched instruction.
- i_Instr  in  32  fetched instruction word.
- o_Ready  out  1  queue can accept a push this cycle.
- i_Flush  in  1  branch/redirect; discard all entries.
- o_Valid  out  1  head entry available to decode.
- o_PC  out  64  PC of the head entry.
- o_Instr  out  32  instruction word of the head entry.
- o_Illegal  out  1  head instruction has bits [1:0] != 2'b11 (compressed/illegal; the core is RV64I only).
- i_Ready  in  1  decode consumes the head this cycle.

Behaviour:
- Storage:
  - Circular array of DEPTH entries, each 96 bits {PC, instruction}.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrap modulo DEPTH.
  - Count register, log2(DEPTH)+1 bits.
- Push occurs when i_Valid && o_Ready && !i_Flush.
- Pop occurs when o_Valid && i_Ready && !i_Flush.
- o_Ready = (count != DEPTH).
  - It is combinational from count only; it does not depend on i_Ready.
  - A push when full is not accepted, even if a pop happens in the same cycle.
- o_Valid = (count != 0).
- o_PC and o_Instr are read combinationally from the head entry.
- When empty, o_PC = 0, o_Instr = NOP and o_Illegal = 0.
- o_Illegal = o_Valid && (o_Instr[1:0] != 2'b11).
- Latency: an entry pushed at edge N appears at o_Valid/o_PC/o_Instr after edge N, i.e. 1 cycle.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Push and pop with count == 0: no pop occurs, because o_Valid = 0.
- Count transitions: +1 on push only, -1 on pop only.
- Flush (i_Flush = 1 at an edge):
  - Pointers and count go to 0.
  - Any same-cycle push or pop is ignored.
  - Flush has priority over every other event.
  - Outputs show the empty state after the edge.
- Reset asserted, at any time including mid-operation: pointers = 0, count = 0, o_Valid = 0, o_Ready = 1, o_PC = 0, o_Instr = NOP, o_Illegal = 0.
- Array contents are not reset and are never observable while count == 0.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0; ordering is preserved across the wrap.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- When defined and the queue is empty, i_Valid = 1 and i_Flush = 0:
  - o_Valid = 1, o_PC = i_PC and o_Instr = i_Instr combinationally (0-cycle latency).
  - If i_Ready = 1 the entry is consumed directly and not written into the array; count stays 0.
  - If i_Ready = 0 the entry is pushed normally.
- When not defined: no combinational path from the i_ side to the o_ side; latency is always 1 cycle.

Decomposition:
- Shared package core_pkg holds:
  - XLEN = 64 and ILEN = 32.
  - The NOP constant 32'h00000013.
  - A fetch-entry struct/width constant {PC[XLEN-1:0], Instr[ILEN-1:0]}, reused by decode.
- One natural sub-module: fq_storage, a DEPTH x 96 register array with a write port and an asynchronous read port.
- Pointer, count and handshake logic stay in fetch_queue.

Test Plan:
- Reset then idle: release i_Reset with i_Valid = 0 -> o_Valid = 0, o_Ready = 1, o_Instr = 32'h00000013, o_PC = 0 for 10 cycles.
- Fill without draining: push PCs 0x0, 0x4, 0x8, 0xC with i_Ready = 0 -> after the 4th edge o_Ready = 0; a 5th push of 0x10 is not accepted; draining yields 0x0, 0x4, 0x8, 0xC in order, then o_Valid = 0.
- Streaming with wrap: continuous push/pop for 12 cycles of PCs 0x100 + 4k -> o_PC sequence equals the input sequence delayed 1 cycle; count stays at 1; pointers wrap 3 times.
- Flush: 3 entries queued, assert i_Flush together with a push of 0x200 -> next cycle o_Valid = 0 and count = 0; 0x200 never appears.
- Illegal flag: push i_Instr = 32'h00004501 -> o_Illegal = 1 when it is at the head; push 32'h00a00513 -> o_Illegal = 0.
- Mid-operation reset: 2 entries queued, pulse i_Reset asynchronously between edges -> o_Valid drops immediately, with no clock edge, and o_Ready = 1; with FETCH_QUEUE_BYPASS_EN, an empty queue with i_Valid = 1 and PC 0x40 -> o_PC = 0x40 in the same cycle.
